// File: rtl/plataform_pkg.sv
// plataform_pkg: shared geometry constants and sweep FSM encoding for the hole scheduler
package plataform_pkg;
  localparam int SCREEN_W = 640;
  localparam int HOLE_WIDTH = 30;
  localparam int POS_W = 10;
  localparam int STEP_W = 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/plataform_hole_scheduler_step.sv
// hole_step_unit: one row's next hole position and direction, bouncing off both screen edges
module hole_step_unit #(
  parameter int SCREEN_W = plataform_pkg::SCREEN_W,
  parameter int HOLE_WIDTH = plataform_pkg::HOLE_WIDTH
) (
  input  logic [plataform_pkg::POS_W-1:0]  i_s,
  input  logic [plataform_pkg::STEP_W-1:0] i_step,
  input  logic                             i_dir,
  output logic [plataform_pkg::POS_W-1:0]  o_s,
  output logic                             o_dir
);
  import plataform_pkg::*;
  logic [POS_W:0] w_ahead;
  logic w_hit_r, w_hit_l;
  // one extra bit so the lookahead past the right edge cannot wrap
  assign w_ahead = {1'b0, i_s} + (POS_W+1)'(i_step) + (POS_W+1)'(HOLE_WIDTH);
  assign w_hit_r = w_ahead >= (POS_W+1)'(SCREEN_W);
  assign w_hit_l = i_s <= POS_W'(i_step);
  assign o_s = (i_step == '0) ? i_s :
               i_dir ? (w_hit_r ? POS_W'(SCREEN_W - HOLE_WIDTH) : i_s + POS_W'(i_step)) :
                       (w_hit_l ? '0 : i_s - POS_W'(i_step));
  assign o_dir = (i_step == '0) ? i_dir : i_dir ? !w_hit_r : w_hit_l;
endmodule

// File: rtl/plataform_hole_scheduler.sv
// plataform_hole_scheduler: tick-paced sweep moving every row's hole through one shared step unit,
// with a config port that places or retunes rows while idle
module plataform_hole_scheduler #(
  parameter int NUM_ROWS = 4,
  parameter int HOLE_WIDTH = plataform_pkg::HOLE_WIDTH,
  parameter int SCREEN_W = plataform_pkg::SCREEN_W,
  parameter int TICK_PERIOD = 840000,
  parameter int ROW_W = 2
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_pause,
  input  logic                                     i_cfg_valid,
  output logic                                     o_cfg_ready,
  input  logic [ROW_W-1:0]                         i_cfg_row,
  input  logic [plataform_pkg::POS_W-1:0]          i_cfg_start,
  input  logic [plataform_pkg::STEP_W-1:0]         i_cfg_step,
  input  logic                                     i_cfg_dir,
  output logic [plataform_pkg::POS_W*NUM_ROWS-1:0] o_hole_start_bus,
  output logic [plataform_pkg::POS_W*NUM_ROWS-1:0] o_hole_end_bus,
  output logic                                     o_sweep_done
);
  import plataform_pkg::*;
  localparam int CNT_W = $clog2(TICK_PERIOD + 1);
  localparam logic [POS_W-1:0] MAX_START = POS_W'(SCREEN_W - HOLE_WIDTH);
  logic [CNT_W-1:0] r_tick_cnt;
  logic [1:0] r_state;
  logic [ROW_W-1:0] r_idx;
  logic [POS_W-1:0] r_start [NUM_ROWS];
  logic [STEP_W-1:0] r_step [NUM_ROWS];
  logic [NUM_ROWS-1:0] r_dir;
  logic w_tick, w_cfg_fire, w_dir_nxt;
  logic [POS_W-1:0] w_start_nxt, w_cfg_start;
  assign w_tick = !i_pause && r_tick_cnt == CNT_W'(TICK_PERIOD - 1);
  assign o_cfg_ready = r_state == IDLE;
  assign o_sweep_done = r_state == DONE;
  assign w_cfg_fire = i_cfg_valid && o_cfg_ready && int'(i_cfg_row) < NUM_ROWS;
  assign w_cfg_start = (i_cfg_start > MAX_START) ? MAX_START : i_cfg_start;
  hole_step_unit #(.SCREEN_W(SCREEN_W), .HOLE_WIDTH(HOLE_WIDTH)) u_step (
    .i_s(r_start[r_idx]),
    .i_step(r_step[r_idx]),
    .i_dir(r_dir[r_idx]),
    .o_s(w_start_nxt),
    .o_dir(w_dir_nxt)
  );
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
      r_state <= IDLE;
      r_idx <= '0;
      r_dir <= '1;
      for (int r = 0; r < NUM_ROWS; r++) begin
        r_start[r] <= POS_W'(r * (SCREEN_W / NUM_ROWS));
        r_step[r] <= STEP_W'(3);
      end
    end else begin
      if (!i_pause) r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_state <= (r_state == IDLE && w_tick) ? SWEEP :
                 (r_state == SWEEP && r_idx == ROW_W'(NUM_ROWS - 1)) ? DONE :
                 (r_state == DONE) ? IDLE : r_state;
      r_idx <= (r_state == SWEEP) ? r_idx + 1'b1 : '0;
      if (r_state == SWEEP) begin
        r_start[r_idx] <= w_start_nxt;
        r_dir[r_idx] <= w_dir_nxt;
      end
      // only possible in IDLE, so it never collides with a sweep write
      if (w_cfg_fire) begin
        r_start[i_cfg_row] <= w_cfg_start;
        r_step[i_cfg_row] <= i_cfg_step;
        r_dir[i_cfg_row] <= i_cfg_dir;
      end
    end
  end
  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_bus
    assign o_hole_start_bus[POS_W*g +: POS_W] = r_start[g];
    assign o_hole_end_bus[POS_W*g +: POS_W] = r_start[g] + POS_W'(HOLE_WIDTH);
  end
endmodule

// File: tb/tb_plataform_hole_scheduler.sv
// tb_plataform_hole_scheduler: directed checks of reset, sweep motion, bounces, config handshake,
// pause and mid-sweep reset with a short tick period
module tb_plataform_hole_scheduler;
  logic clk = 0, rst_n = 0, pause = 0, cfg_valid = 0, cfg_dir = 0;
  logic cfg_ready, sweep_done;
  logic [1:0] cfg_row = '0;
  logic [9:0] cfg_start = '0;
  logic [3:0] cfg_step = '0;
  logic [39:0] start_bus, end_bus;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  plataform_hole_scheduler #(.NUM_ROWS(4), .HOLE_WIDTH(30), .SCREEN_W(640), .TICK_PERIOD(8), .ROW_W(2)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_pause(pause),
    .i_cfg_valid(cfg_valid),
    .o_cfg_ready(cfg_ready),
    .i_cfg_row(cfg_row),
    .i_cfg_start(cfg_start),
    .i_cfg_step(cfg_step),
    .i_cfg_dir(cfg_dir),
    .o_hole_start_bus(start_bus),
    .o_hole_end_bus(end_bus),
    .o_sweep_done(sweep_done)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int hs(input int r);
    return int'(start_bus[10*r +: 10]);
  endfunction
  function automatic int he(input int r);
    return int'(end_bus[10*r +: 10]);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sweep_done && n < 40);
    check("done_seen", int'(sweep_done), 1);
  endtask
  task automatic cfg(input int row, input int start, input int stp, input int dir);
    int n;
    logic acc;
    n = 0;
    cfg_row = 2'(row);
    cfg_start = 10'(start);
    cfg_step = 4'(stp);
    cfg_dir = dir[0];
    cfg_valid = 1;
    do begin
      @(negedge clk);
      acc = cfg_ready;
      step();
      n++;
    end while (!acc && n < 40);
    cfg_valid = 0;
    check("cfg_accepted", int'(acc), 1);
  endtask
  task automatic check_defaults(input string tag);
    for (int r = 0; r < 4; r++) begin
      check({tag, "_start"}, hs(r), r * 160);
      check({tag, "_end"}, he(r), r * 160 + 30);
    end
    check({tag, "_ready"}, int'(cfg_ready), 1);
    check({tag, "_done"}, int'(sweep_done), 0);
  endtask
  initial begin
    int n, p, seen;
    repeat (2) step();
    rst_n = 1;
    check_defaults("rst");
    wait_done(n);
    for (int r = 0; r < 4; r++) check("sweep1_start", hs(r), r * 160 + 3);
    step();
    check("done_pulse_width", int'(sweep_done), 0);
    wait_done(n);
    check("done_interval", n, 7);
    for (int r = 0; r < 4; r++) check("sweep2_start", hs(r), r * 160 + 6);
    cfg(1, 608, 3, 1);
    check("row1_cfg", hs(1), 608);
    check("row1_cfg_end", he(1), 638);
    wait_done(n);
    check("row1_bounce_r", hs(1), 610);
    check("row1_bounce_r_end", he(1), 640);
    wait_done(n);
    check("row1_move_left", hs(1), 607);
    cfg(2, 2, 3, 0);
    check("row2_cfg", hs(2), 2);
    wait_done(n);
    check("row2_bounce_l", hs(2), 0);
    wait_done(n);
    check("row2_move_right", hs(2), 3);
    cfg(3, 700, 0, 1);
    check("row3_clamp", hs(3), 610);
    wait_done(n);
    check("row3_frozen", hs(3), 610);
    step();
    p = 0;
    while (cfg_ready && p < 40) begin
      step();
      p++;
    end
    check("sweep_ready_low", int'(cfg_ready), 0);
    cfg(0, 100, 2, 1);
    check("pending_cfg_lands", hs(0), 100);
    wait_done(n);
    check("pending_cfg_moves", hs(0), 102);
    pause = 1;
    seen = 0;
    repeat (30) begin
      step();
      if (sweep_done) seen++;
    end
    check("pause_no_sweep", seen, 0);
    check("pause_row0_hold", hs(0), 102);
    pause = 0;
    p = 0;
    do begin
      step();
      p++;
    end while (cfg_ready && p < 40);
    check("resume_latency", p, 4);
    step();
    step();
    check("mid_sweep_row0", hs(0), 104);
    rst_n = 0;
    step();
    rst_n = 1;
    check_defaults("midrst");
    wait_done(n);
    for (int r = 0; r < 4; r++) check("post_rst_sweep", hs(r), r * 160 + 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
